lcd_nibble_writer: RTL

//  Physical layer for the character LCD (4-bit bus, write-only). Sits directly below the
//  LCD transaction layer: takes one byte plus register-select per request, sends it as two

---
 rtl/lcd_nibble_writer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_writer.sv
// Write-only 4-bit character LCD physical layer: each byte goes out as two nibbles with LCDE strobe timing, then a byte execution gap.
// Define LCD_NIBBLE_INIT_EN to run the LCD power-on nibble sequence (0x3,0x3,0x3,0x2) after reset before accepting requests.
module lcd_nibble_writer #(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int BYTE_GAP_CYC   = 2000,
    parameter int POWERUP_CYC    = 750000,
    parameter int INIT_LONG_CYC  = 205000,
    parameter int INIT_SHORT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       done,
    output logic       LCDE,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic [3:0] LCDDAT
);

    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
    localparam logic [19:0] PULSE_LD = 20'(PULSE_CYC - 1);
    localparam logic [19:0] NGAP_LD  = 20'(NIBBLE_GAP_CYC - 1);
    localparam logic [19:0] BGAP_LD  = 20'(BYTE_GAP_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        SETUP_HI,
        PULSE_HI,
        GAP_NIB,
        SETUP_LO,
        PULSE_LO,
        GAP_BYTE
`ifdef LCD_NIBBLE_INIT_EN
        ,
        INIT_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_GAP
`endif
    } state_t;

`ifdef LCD_NIBBLE_INIT_EN
    localparam logic [19:0] PWR_LD   = 20'(POWERUP_CYC - 1);
    localparam logic [19:0] LONG_LD  = 20'(INIT_LONG_CYC - 1);
    localparam logic [19:0] SHORT_LD = 20'(INIT_SHORT_CYC - 1);
    localparam state_t      RESET_STATE = INIT_WAIT;
    localparam logic [19:0] RESET_CNT   = PWR_LD;
    localparam logic        RESET_READY = 1'b0;
`else
    localparam state_t      RESET_STATE = IDLE;
    localparam logic [19:0] RESET_CNT   = 20'd0;
    localparam logic        RESET_READY = 1'b1;
`endif

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic [7:0]  data_q, data_n;
    logic        rs_q, rs_n;

    logic        e_n, rs_o_n, done_n, ready_n;
    logic [3:0]  dat_n;

`ifdef LCD_NIBBLE_INIT_EN
    logic [1:0]  init_step, init_step_n;

    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // The wait after each init nibble shrinks as the controller gets closer to 4-bit mode.
    function automatic logic [19:0] init_gap_ld(input logic [1:0] step);
        case (step)
            2'd0:    return LONG_LD;
            2'd1:    return SHORT_LD;
            default: return BGAP_LD;
        endcase
    endfunction
`endif

    assign LCDRW = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RESET_STATE;
            cnt    <= RESET_CNT;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            LCDE   <= 1'b0;
            LCDRS  <= 1'b0;
            LCDDAT <= 4'h0;
            done   <= 1'b0;
            ready  <= RESET_READY;
`ifdef LCD_NIBBLE_INIT_EN
            init_step <= 2'd0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            rs_q   <= rs_n;
            LCDE   <= e_n;
            LCDRS  <= rs_o_n;
            LCDDAT <= dat_n;
            done   <= done_n;
            ready  <= ready_n;
`ifdef LCD_NIBBLE_INIT_EN
            init_step <= init_step_n;
`endif
        end
    end

    // Every timed state reloads the shared down-counter on entry and leaves when it reaches zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        rs_n    = rs_q;
`ifdef LCD_NIBBLE_INIT_EN
        init_step_n = init_step;
`endif
        case (state)
            IDLE: begin
                cnt_n = 20'd0;
                if (start) begin
                    data_n  = data_in;
                    rs_n    = rs_in;
                    state_n = SETUP_HI;
                    cnt_n   = SETUP_LD;
                end
            end
            SETUP_HI: begin
                if (cnt == 20'd0) begin
                    state_n = PULSE_HI;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            PULSE_HI: begin
                if (cnt == 20'd0) begin
                    state_n = GAP_NIB;
                    cnt_n   = NGAP_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            GAP_NIB: begin
                if (cnt == 20'd0) begin
                    state_n = SETUP_LO;
                    cnt_n   = SETUP_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            SETUP_LO: begin
                if (cnt == 20'd0) begin
                    state_n = PULSE_LO;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            PULSE_LO: begin
                if (cnt == 20'd0) begin
                    state_n = GAP_BYTE;
                    cnt_n   = BGAP_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            GAP_BYTE: begin
                if (cnt == 20'd0) begin
                    state_n = IDLE;
                    cnt_n   = 20'd0;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
`ifdef LCD_NIBBLE_INIT_EN
            INIT_WAIT: begin
                if (cnt == 20'd0) begin
                    state_n     = INIT_SETUP;
                    cnt_n       = SETUP_LD;
                    init_step_n = 2'd0;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            INIT_SETUP: begin
                if (cnt == 20'd0) begin
                    state_n = INIT_PULSE;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            INIT_PULSE: begin
                if (cnt == 20'd0) begin
                    state_n = INIT_GAP;
                    cnt_n   = init_gap_ld(init_step);
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
            INIT_GAP: begin
                if (cnt == 20'd0) begin
                    if (init_step == 2'd3) begin
                        state_n = IDLE;
                        cnt_n   = 20'd0;
                    end else begin
                        state_n     = INIT_SETUP;
                        cnt_n       = SETUP_LD;
                        init_step_n = init_step + 2'd1;
                    end
                end else begin
                    cnt_n = cnt - 20'd1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = 20'd0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they register in lockstep with it;
    // data/RS settle in the SETUP states, which keeps LCDE edges apart from bus changes.
    always_comb begin
        e_n     = 1'b0;
        rs_o_n  = 1'b0;
        dat_n   = 4'h0;
        done_n  = 1'b0;
        ready_n = 1'b0;
        case (state_n)
            IDLE: ready_n = 1'b1;
            SETUP_HI, GAP_NIB: begin
                dat_n  = data_n[7:4];
                rs_o_n = rs_n;
            end
            PULSE_HI: begin
                dat_n  = data_n[7:4];
                rs_o_n = rs_n;
                e_n    = 1'b1;
            end
            SETUP_LO: begin
                dat_n  = data_n[3:0];
                rs_o_n = rs_n;
            end
            PULSE_LO: begin
                dat_n  = data_n[3:0];
                rs_o_n = rs_n;
                e_n    = 1'b1;
            end
            GAP_BYTE: begin
                dat_n  = data_n[3:0];
                rs_o_n = rs_n;
                done_n = (cnt_n == 20'd0);
            end
`ifdef LCD_NIBBLE_INIT_EN
            INIT_SETUP, INIT_GAP: dat_n = init_nibble(init_step_n);
            INIT_PULSE: begin
                dat_n = init_nibble(init_step_n);
                e_n   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
